// File: rtl/tx_arb.sv
// -----------------------------------------------------------------------------
// tx_arb -- round-robin arbiter in front of the single UART transmitter.
//
// Each requester owns a one-word holding slot. In IDLE, with the transmitter
// ready, one pending slot is chosen and issued. The choice is round-robin
// starting after the last owner, or only the owner while it holds its lock
// bit. The word goes out as a one-cycle strobe on tx_stb_o with the word on
// tx_o. The arbiter then passes through ACK and waits in BUSY until the
// transmitter reports ready again.
//
// Ports:
//   clk_i       system clock
//   rst_in      asynchronous active-low reset
//   req_stb_i   [N]        one-cycle write strobe per requester
//   req_data_i  [N*WIDTH]  word r at bits [r*WIDTH +: WIDTH]
//   req_lock_i  [N]        current owner keeps the grant while its bit is high
//   req_rdy_o   [N]        slot free or being issued this cycle (combinational)
//   clr_i                  clears the sticky overflow flag
//   tx_rdy_i               transmitter idle
//   tx_stb_o               one-cycle start strobe to the transmitter
//   tx_o        [WIDTH]    word to send, held until the next issue
//   gnt_o       [N]        one-hot owner of the last issued word
//   ovf_o                  sticky: a strobe hit a full slot and was dropped
// -----------------------------------------------------------------------------
module tx_arb #(
    parameter int N     = 2,
    parameter int WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_in,
    input  logic [N-1:0]         req_stb_i,
    input  logic [N*WIDTH-1:0]   req_data_i,
    input  logic [N-1:0]         req_lock_i,
    output logic [N-1:0]         req_rdy_o,
    input  logic                 clr_i,
    input  logic                 tx_rdy_i,
    output logic                 tx_stb_o,
    output logic [WIDTH-1:0]     tx_o,
    output logic [N-1:0]         gnt_o,
    output logic                 ovf_o
);

    localparam int LW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        BUSY = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               arb_en;

    logic [N-1:0]       valid;
    logic [WIDTH-1:0]   slot_data [N];
    logic [N-1:0]       drop;

    logic               owner_locked;
    logic [N-1:0]       elig;
    logic [LW-1:0]      sel;
    logic [LW-1:0]      cand;
    logic               found;
    logic               issue;

    logic [LW-1:0]      last_q, last_d;
    logic [N-1:0]       gnt_q, gnt_d;
    logic [WIDTH-1:0]   tx_q, tx_d;
    logic               stb_q, stb_d;
    logic               ovf_q, ovf_d;

    // ---------------------------------------------------------------- slots
    for (genvar gi = 0; gi < N; gi++) begin : g_slot
        logic               valid_q;
        logic [WIDTH-1:0]   data_q;
        logic               issued;
        logic               load;

        assign issued = issue & (sel == LW'(gi));
        // An issued slot accepts a same-cycle strobe: the old word leaves
        // through tx_d while the new one takes its place (write-through).
        assign load      = req_stb_i[gi] & (~valid_q | issued);
        assign drop[gi]  = req_stb_i[gi] & valid_q & ~issued;
        assign req_rdy_o[gi] = ~valid_q | issued;
        assign valid[gi]     = valid_q;
        assign slot_data[gi] = data_q;

        always_ff @(posedge clk_i or negedge rst_in) begin
            if (!rst_in) begin
                valid_q <= 1'b0;
                data_q  <= '0;
            end else if (load) begin
                valid_q <= 1'b1;
                data_q  <= req_data_i[gi*WIDTH +: WIDTH];
            end else if (issued) begin
                valid_q <= 1'b0;
            end
        end
    end

    // ---------------------------------------------------------- arbitration
    // While the owner holds its lock only its own slot may win; an empty
    // owner slot then stalls arbitration rather than falling back.
    assign owner_locked = |(gnt_q & req_lock_i);
    assign elig         = owner_locked ? (valid & gnt_q) : valid;

    // Walk the requesters starting just after the last owner, wrapping at N.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        cand  = last_q;
        for (int k = 0; k < N; k++) begin
            cand = (cand == LW'(N - 1)) ? '0 : cand + 1'b1;
            if (!found && elig[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    assign issue = arb_en & tx_rdy_i & found;

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (issue) state_d = ACK;
            // tx_rdy_i may still be high here while the transmitter picks up
            // the strobe, so it is not looked at until BUSY.
            ACK:     state_d = BUSY;
            BUSY:    if (tx_rdy_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        arb_en = 1'b0;
        if (state_q == IDLE) begin
            arb_en = 1'b1;
        end
    end

    // ------------------------------------------------------------- datapath
    always_comb begin
        last_d = last_q;
        gnt_d  = gnt_q;
        tx_d   = tx_q;
        stb_d  = issue;
        if (issue) begin
            last_d = sel;
            gnt_d  = N'(1) << sel;
            tx_d   = slot_data[sel];
        end
        // A drop in the same cycle as a clear keeps the flag set.
        if (|drop) begin
            ovf_d = 1'b1;
        end else if (clr_i) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            last_q <= LW'(N - 1);
            gnt_q  <= '0;
            tx_q   <= '0;
            stb_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            last_q <= last_d;
            gnt_q  <= gnt_d;
            tx_q   <= tx_d;
            stb_q  <= stb_d;
            ovf_q  <= ovf_d;
        end
    end

    assign tx_stb_o = stb_q;
    assign tx_o     = tx_q;
    assign gnt_o    = gnt_q;
    assign ovf_o    = ovf_q;

endmodule

// File: tb/tb_tx_arb.sv
// -----------------------------------------------------------------------------
// tb_tx_arb -- directed self-checking bench for tx_arb (N=2, WIDTH=32).
//
// A small transmitter model inside tick() drops tx_rdy_i in the strobe cycle
// and raises it again busy_len cycles later. Inputs are driven and outputs
// sampled 2 time units after each rising edge.
// -----------------------------------------------------------------------------
module tb_tx_arb;

    localparam int N = 2;
    localparam int W = 32;

    logic             clk_i;
    logic             rst_in;
    logic [N-1:0]     req_stb_i;
    logic [N*W-1:0]   req_data_i;
    logic [N-1:0]     req_lock_i;
    logic [N-1:0]     req_rdy_o;
    logic             clr_i;
    logic             tx_rdy_i;
    logic             tx_stb_o;
    logic [W-1:0]     tx_o;
    logic [N-1:0]     gnt_o;
    logic             ovf_o;

    int n_checks;
    int n_pass;
    int cyc;
    bit auto_tx;
    int busy_cnt;
    int busy_len;
    int last_rise;

    tx_arb #(.N(N), .WIDTH(W)) dut (
        .clk_i      (clk_i),
        .rst_in     (rst_in),
        .req_stb_i  (req_stb_i),
        .req_data_i (req_data_i),
        .req_lock_i (req_lock_i),
        .req_rdy_o  (req_rdy_o),
        .clr_i      (clr_i),
        .tx_rdy_i   (tx_rdy_i),
        .tx_stb_o   (tx_stb_o),
        .tx_o       (tx_o),
        .gnt_o      (gnt_o),
        .ovf_o      (ovf_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // One clock; transmitter model reacts to the registered strobe.
    task automatic tick();
        @(posedge clk_i);
        #1;
        cyc = cyc + 1;
        if (auto_tx) begin
            if (tx_stb_o === 1'b1) begin
                tx_rdy_i = 1'b0;
                busy_cnt = busy_len;
            end else if (busy_cnt > 0) begin
                busy_cnt = busy_cnt - 1;
                if (busy_cnt == 0) begin
                    tx_rdy_i  = 1'b1;
                    last_rise = cyc;
                end
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst_in     = 1'b0;
        req_stb_i  = '0;
        req_lock_i = '0;
        req_data_i = '0;
        clr_i      = 1'b0;
        tx_rdy_i   = 1'b1;
        auto_tx    = 1'b1;
        busy_cnt   = 0;
        tick();
        tick();
        rst_in = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_in     = 1'b0;
        req_stb_i  = '0;
        req_lock_i = '0;
        req_data_i = '0;
        clr_i      = 1'b0;
        tx_rdy_i   = 1'b1;
        tick();
        n_checks++;
        if ({tx_stb_o, tx_o, gnt_o, ovf_o} !== 36'd0) $display("FAIL reset_outputs: got stb=%b tx=%h gnt=%b ovf=%b, need all 0", tx_stb_o, tx_o, gnt_o, ovf_o);
        else n_pass++;
        n_checks++;
        if (req_rdy_o !== 2'b11) $display("FAIL reset_rdy: got %b need 11", req_rdy_o);
        else n_pass++;
        rst_in = 1'b1;
        repeat (3) tick();
        n_checks++;
        if (tx_stb_o !== 1'b0) $display("FAIL reset_idle: got stb=%b need 0", tx_stb_o);
        else n_pass++;
    endtask

    task automatic test_single_word();
        int n_stb;
        do_reset();
        req_data_i[31:0] = 32'hDEAD_BEEF;
        req_stb_i        = 2'b01;
        tick();
        req_stb_i = '0;
        n_checks++;
        if (tx_stb_o !== 1'b0) $display("FAIL single_early: got stb=%b need 0", tx_stb_o);
        else n_pass++;
        tick();
        $display("issue cyc=%0d tx=%h gnt=%b", cyc, tx_o, gnt_o);
        n_checks++;
        if (tx_stb_o !== 1'b1) $display("FAIL single_stb: got %b need 1", tx_stb_o);
        else n_pass++;
        n_checks++;
        if (tx_o !== 32'hDEAD_BEEF) $display("FAIL single_data: got %h need deadbeef", tx_o);
        else n_pass++;
        n_checks++;
        if (gnt_o !== 2'b01) $display("FAIL single_gnt: got %b need 01", gnt_o);
        else n_pass++;
        n_stb = 0;
        repeat (12) begin
            tick();
            if (tx_stb_o === 1'b1) n_stb++;
        end
        n_checks++;
        if (n_stb != 0) $display("FAIL single_extra: got %0d extra strobes need 0", n_stb);
        else n_pass++;
        n_checks++;
        if (tx_o !== 32'hDEAD_BEEF) $display("FAIL single_hold: got %h need deadbeef", tx_o);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        int n;
        bit refill;
        logic [W-1:0] exp_w;
        logic [N-1:0] exp_g;
        do_reset();
        req_data_i = {32'h2222_2222, 32'h1111_1111};
        req_stb_i  = 2'b11;
        n      = 0;
        refill = 1'b1;
        for (int i = 0; i < 60 && n < 3; i++) begin
            tick();
            req_stb_i = '0;
            if (tx_stb_o === 1'b1) begin
                $display("issue cyc=%0d tx=%h gnt=%b", cyc, tx_o, gnt_o);
                exp_w = (n % 2 == 0) ? 32'h1111_1111 : 32'h2222_2222;
                exp_g = (n % 2 == 0) ? 2'b01 : 2'b10;
                n_checks++;
                if (tx_o !== exp_w) $display("FAIL rr_data%0d: got %h need %h", n, tx_o, exp_w);
                else n_pass++;
                n_checks++;
                if (gnt_o !== exp_g) $display("FAIL rr_gnt%0d: got %b need %b", n, gnt_o, exp_g);
                else n_pass++;
                if (n > 0) begin
                    n_checks++;
                    if (cyc - last_rise != 2) $display("FAIL rr_spacing%0d: got %0d cycles after rdy rise need 2", n, cyc - last_rise);
                    else n_pass++;
                end
                n++;
                if (n == 3) refill = 1'b0;
            end
            if (refill) req_stb_i = req_rdy_o;
        end
        n_checks++;
        if (n != 3) $display("FAIL rr_count: got %0d issues need 3", n);
        else n_pass++;
    endtask

    task automatic test_lock();
        int n;
        int loads0;
        int s4;
        logic [W-1:0] exp_w;
        logic [N-1:0] exp_g;
        do_reset();
        req_lock_i = 2'b01;
        req_data_i = {32'hB1B1_B1B1, 32'hA000_0000};
        req_stb_i  = 2'b11;
        loads0 = 1;
        n      = 0;
        s4     = 0;
        for (int i = 0; i < 100 && n < 6; i++) begin
            tick();
            req_stb_i = '0;
            if (tx_stb_o === 1'b1) begin
                $display("issue cyc=%0d tx=%h gnt=%b", cyc, tx_o, gnt_o);
                if (n < 4)       exp_w = 32'hA000_0000 + 32'(n);
                else if (n == 4) exp_w = 32'hB1B1_B1B1;
                else             exp_w = 32'hA000_0004;
                exp_g = (n == 4) ? 2'b10 : 2'b01;
                n_checks++;
                if (tx_o !== exp_w) $display("FAIL lock_data%0d: got %h need %h", n, tx_o, exp_w);
                else n_pass++;
                n_checks++;
                if (gnt_o !== exp_g) $display("FAIL lock_gnt%0d: got %b need %b", n, gnt_o, exp_g);
                else n_pass++;
                if (n == 4) begin
                    n_checks++;
                    if (cyc != s4 + 6) $display("FAIL lock_release: got issue at +%0d need +6", cyc - s4);
                    else n_pass++;
                end
                if (n == 3) s4 = cyc;
                n++;
            end
            // Drop the lock exactly in the decision cycle after the 4th issue.
            if (n == 4 && cyc == s4 + 5) begin
                req_lock_i = 2'b00;
                #1;
            end
            if (req_rdy_o[0] === 1'b1 && loads0 < 5) begin
                req_data_i[31:0] = 32'hA000_0000 + 32'(loads0);
                req_stb_i[0]     = 1'b1;
                loads0++;
            end
        end
        n_checks++;
        if (n != 6) $display("FAIL lock_count: got %0d issues need 6", n);
        else n_pass++;
    endtask

    task automatic test_overflow();
        int n_stb;
        do_reset();
        auto_tx  = 1'b0;
        tx_rdy_i = 1'b0;
        req_data_i[63:32] = 32'h0000_0111;
        req_stb_i = 2'b10;
        tick();
        req_data_i[63:32] = 32'h0000_0222;
        req_stb_i = 2'b10;
        n_checks++;
        if (req_rdy_o !== 2'b01) $display("FAIL ovf_rdy_full: got %b need 01", req_rdy_o);
        else n_pass++;
        tick();
        req_stb_i = '0;
        n_checks++;
        if (ovf_o !== 1'b1) $display("FAIL ovf_set: got %b need 1", ovf_o);
        else n_pass++;
        tx_rdy_i = 1'b1;
        auto_tx  = 1'b1;
        tick();
        $display("issue cyc=%0d tx=%h gnt=%b", cyc, tx_o, gnt_o);
        n_checks++;
        if (tx_stb_o !== 1'b1 || tx_o !== 32'h0000_0111) $display("FAIL ovf_first_word: got stb=%b tx=%h need 1/00000111", tx_stb_o, tx_o);
        else n_pass++;
        n_checks++;
        if (gnt_o !== 2'b10) $display("FAIL ovf_gnt: got %b need 10", gnt_o);
        else n_pass++;
        n_stb = 0;
        repeat (10) begin
            tick();
            if (tx_stb_o === 1'b1) n_stb++;
        end
        n_checks++;
        if (n_stb != 0) $display("FAIL ovf_dropped: got %0d extra strobes need 0", n_stb);
        else n_pass++;
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        n_checks++;
        if (ovf_o !== 1'b0) $display("FAIL ovf_clr: got %b need 0", ovf_o);
        else n_pass++;
        auto_tx  = 1'b0;
        tx_rdy_i = 1'b0;
        req_data_i[63:32] = 32'h0000_0333;
        req_stb_i = 2'b10;
        tick();
        req_data_i[63:32] = 32'h0000_0444;
        req_stb_i = 2'b10;
        clr_i     = 1'b1;
        tick();
        req_stb_i = '0;
        clr_i     = 1'b0;
        n_checks++;
        if (ovf_o !== 1'b1) $display("FAIL ovf_set_wins: got %b need 1", ovf_o);
        else n_pass++;
    endtask

    task automatic test_write_through();
        int t1;
        int t2;
        bit found;
        do_reset();
        req_data_i[31:0] = 32'h0000_0005;
        req_stb_i = 2'b01;
        tick();
        req_data_i[31:0] = 32'h0000_000A;
        req_stb_i = 2'b01;
        n_checks++;
        if (req_rdy_o[0] !== 1'b1) $display("FAIL wt_rdy_issue: got %b need 1", req_rdy_o[0]);
        else n_pass++;
        tick();
        req_stb_i = '0;
        t1 = cyc;
        $display("issue cyc=%0d tx=%h gnt=%b", cyc, tx_o, gnt_o);
        n_checks++;
        if (tx_stb_o !== 1'b1 || tx_o !== 32'h0000_0005) $display("FAIL wt_old_word: got stb=%b tx=%h need 1/00000005", tx_stb_o, tx_o);
        else n_pass++;
        found = 1'b0;
        t2    = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (tx_stb_o === 1'b1) begin
                found = 1'b1;
                t2    = cyc;
                $display("issue cyc=%0d tx=%h gnt=%b", cyc, tx_o, gnt_o);
            end
        end
        n_checks++;
        if (!found || tx_o !== 32'h0000_000A) $display("FAIL wt_new_word: got found=%b tx=%h need 1/0000000a", found, tx_o);
        else n_pass++;
        n_checks++;
        if (t2 - t1 != 6) $display("FAIL wt_spacing: got %0d need 6", t2 - t1);
        else n_pass++;
        n_checks++;
        if (ovf_o !== 1'b0) $display("FAIL wt_no_ovf: got %b need 0", ovf_o);
        else n_pass++;
    endtask

    task automatic test_reset_mid_busy();
        int n_stb;
        do_reset();
        req_data_i[31:0] = 32'h0000_0077;
        req_stb_i = 2'b01;
        tick();
        req_stb_i = '0;
        tick();
        $display("issue cyc=%0d tx=%h gnt=%b", cyc, tx_o, gnt_o);
        tick();
        req_data_i[63:32] = 32'h0000_0088;
        req_stb_i = 2'b10;
        tick();
        req_stb_i = '0;
        #1;
        rst_in = 1'b0;
        #1;
        n_checks++;
        if ({tx_stb_o, tx_o, gnt_o, ovf_o} !== 36'd0) $display("FAIL rst_async: got stb=%b tx=%h gnt=%b ovf=%b, need all 0", tx_stb_o, tx_o, gnt_o, ovf_o);
        else n_pass++;
        n_checks++;
        if (req_rdy_o !== 2'b11) $display("FAIL rst_slots: got %b need 11", req_rdy_o);
        else n_pass++;
        #2;
        rst_in   = 1'b1;
        auto_tx  = 1'b0;
        busy_cnt = 0;
        tx_rdy_i = 1'b1;
        n_stb = 0;
        repeat (8) begin
            tick();
            if (tx_stb_o === 1'b1) n_stb++;
        end
        n_checks++;
        if (n_stb != 0) $display("FAIL rst_no_stb: got %0d strobes need 0", n_stb);
        else n_pass++;
        req_data_i = {32'h0000_00C1, 32'h0000_00C0};
        req_stb_i  = 2'b11;
        tick();
        req_stb_i = '0;
        tick();
        $display("issue cyc=%0d tx=%h gnt=%b", cyc, tx_o, gnt_o);
        n_checks++;
        if (tx_stb_o !== 1'b1 || tx_o !== 32'h0000_00C0 || gnt_o !== 2'b01) $display("FAIL rst_priority: got stb=%b tx=%h gnt=%b need 1/000000c0/01", tx_stb_o, tx_o, gnt_o);
        else n_pass++;
    endtask

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        cyc        = 0;
        auto_tx    = 1'b0;
        busy_cnt   = 0;
        busy_len   = 4;
        last_rise  = 0;
        test_reset();
        test_single_word();
        test_round_robin();
        test_lock();
        test_overflow();
        test_write_through();
        test_reset_mid_busy();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tx_arb.md
# tx_arb

Round-robin transmit arbiter that shares the single UART transmitter between several word sources: the sample dump path from the controller, configuration/ID readback, and future metadata sources. Each requester gets a one-word holding slot. The arbiter picks one pending word at a time, strobes the transmitter, and waits out the transmitter's busy phase before issuing the next word. A lock input lets one requester (the sample dump) own the transmitter for a burst. It sits between the requesters and the transmitter and replaces the static ram/readback mux in the core.

## Interface
- N, 2, number of requesters; index 0 has the highest priority after reset
- WIDTH, 32, word width
- clk_i  in  1  system clock
- rst_in  in  1  reset; asynchronous, active-low
- req_stb_i  in  N  one-cycle strobe per requester; the matching slice of req_data_i is valid in that cycle
- req_data_i  in  N*WIDTH  word r occupies bits [r*WIDTH +: WIDTH]
- req_lock_i  in  N  the current owner keeps the grant while its bit is high
- req_rdy_o  out  N  slot r is free or is being issued this cycle; combinational
- clr_i  in  1  clears ovf_o
- tx_rdy_i  in  1  transmitter idle
- tx_stb_o  out  1  one-cycle start strobe to the transmitter; registered
- tx_o  out  WIDTH  word to send; registered, held until the next issue
- gnt_o  out  N  one-hot owner of the last issued word; registered
- ovf_o  out  1  sticky flag: a strobe hit a full slot and the word was dropped

## Operation
- Slots: slot r holds a WIDTH-bit data register plus a valid bit.
  - req_stb_i[r] with the slot free loads the word and sets valid.
  - req_stb_i[r] with the slot full and not being issued drops the word, keeps the old one, and sets ovf_o.
- Write-through: if slot r is issued in the decision cycle and req_stb_i[r] is high in that same cycle, the new word loads and valid stays 1.
- req_rdy_o[r] = ~valid[r] | (issue & sel == r).
- Arbitration happens only in IDLE with tx_rdy_i=1 and at least one valid slot.
  - If gnt_o[o]=1 and req_lock_i[o]=1: only slot o is eligible. With slot o empty, nothing issues and the arbiter waits.
  - Otherwise: round-robin search starting at last_owner+1 and wrapping mod N.
- Issue, at the edge that ends the decision cycle:
  - tx_o is loaded with the selected slot.
  - tx_stb_o is set for exactly one cycle.
  - gnt_o is set to the selected requester, and last_owner is updated.
  - valid of the selected slot is cleared, unless write-through applies.
- FSM:
  - IDLE -> ACK on issue.
  - ACK -> BUSY unconditionally; tx_rdy_i is ignored in ACK.
  - BUSY -> IDLE when tx_rdy_i=1.
- ovf_o: set on any drop and cleared by clr_i. If both happen in the same cycle, set wins.
- Reset values: all slots invalid, data 0, tx_stb_o=0, tx_o=0, gnt_o=0, ovf_o=0, state IDLE, last_owner=N-1 (so requester 0 wins first).
- Reset asserted mid-transfer aborts immediately: pending words are lost and no strobe is issued after release until a new request arrives.

## Timing
- req_stb_i in cycle t (slot free, IDLE, tx_rdy_i=1):
  - valid is set at t+1, and t+1 is the decision cycle.
  - tx_stb_o is high in cycle t+2, with tx_o valid from t+2.
- Minimum issue spacing is 3 cycles: issue cycle, ACK, then at least one BUSY cycle.
- Transmitter contract:
  - tx_rdy_i goes low no later than the cycle after the cycle in which tx_stb_o is high.
  - tx_rdy_i returns high when the transmitter is ready for the next word.
- tx_o is stable from its issue cycle until the next issue.
- Lock release: in the cycle req_lock_i[owner] falls, that cycle's IDLE decision already uses round-robin.
- Simultaneous strobes on all requesters are all accepted into their slots and drain in round-robin order.

## Test plan
- Single word: N=2, req_stb_i=01, data 0xDEADBEEF, tx_rdy_i=1, transmitter busy 4 cycles -> tx_stb_o high exactly 2 cycles after the strobe, tx_o=0xDEADBEEF, gnt_o=01, no second strobe.
- Round-robin: both requesters strobe in the same cycle (0x11111111, 0x22222222), then both refill every time req_rdy_o is high -> tx_o alternates 0x11111111, 0x22222222, 0x11111111, and each strobe follows the previous tx_rdy_i rise.
- Lock: requester 0 holds req_lock_i=1 and sends 4 words while requester 1 stays pending -> four issues from 0 in a row. Lock drops in the decision cycle -> requester 1 wins next.
- Overflow: two strobes from requester 1 while tx_rdy_i=0 -> second word dropped, ovf_o=1, the first word is sent. clr_i pulse -> ovf_o=0. Set and clr in the same cycle -> ovf_o stays 1.
- Write-through: requester 0 strobes 0xA in its own decision cycle -> the old word issues, 0xA is issued next, ovf_o stays 0.
- Reset mid-BUSY with a pending slot -> all outputs are 0 asynchronously. After release with tx_rdy_i=1 -> no tx_stb_o until a new strobe arrives, and requester 0 has priority.
